// File: rtl/avalon_pkg.sv
// Shared types and width helpers for the Avalon burst master and its length FIFO.
package avalon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_e;

  // User burst lengths run 1..256, so lengths and remaining-beat counts need 9 bits.
  localparam int LEN_W = 9;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Width of avm_burstcount: must be able to hold C_MAX_BURST itself.
  function automatic int burst_cnt_width(input int max_burst);
    return clog2(max_burst) + 1;
  endfunction

  // Width of the in-sub-burst beat counter, which only counts 0..max_burst-1.
  function automatic int beat_cnt_width(input int max_burst);
    return (clog2(max_burst) > 0) ? clog2(max_burst) : 1;
  endfunction

endpackage

// File: rtl/avalon_len_fifo.sv
// Small synchronous FIFO holding the beat count of each accepted read command
// until its data has fully returned. Push and pop in the same cycle are both honoured.
module avalon_len_fifo
  import avalon_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy; pointers wrap since DEPTH is a power of 2.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Register stage; reset empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/avalon_burst_master.sv
// Bridges an AXI-like user master onto an Avalon-MM pipelined burst master,
// splitting long user bursts into Avalon sub-bursts and generating rlast.
module avalon_burst_master
  import avalon_pkg::*;
#(
  parameter int C_AVM_ADDR_WIDTH  = 32,
  parameter int C_AVM_DATA_WIDTH  = 32,
  parameter logic [C_AVM_ADDR_WIDTH-1:0] C_AVM_TARGET = '0,
  parameter int C_MAX_BURST       = 16,
  parameter int C_MAX_OUTSTANDING = 4,
  localparam int BCW = burst_cnt_width(C_MAX_BURST)
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [C_AVM_ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]                    awlen,
  input  logic                          awvalid,
  output logic                          awready,
  input  logic [C_AVM_DATA_WIDTH-1:0]   wdata,
  input  logic [C_AVM_DATA_WIDTH/8-1:0] wstrb,
  input  logic                          wlast,
  input  logic                          wvalid,
  output logic                          wready,
  input  logic [C_AVM_ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]                    arlen,
  input  logic                          arvalid,
  output logic                          arready,
  output logic [C_AVM_DATA_WIDTH-1:0]   rdata,
  output logic                          rlast,
  output logic                          rvalid,
  input  logic                          rready,
  output logic                          error,
  output logic [C_AVM_ADDR_WIDTH-1:0]   avm_address,
  output logic [BCW-1:0]                avm_burstcount,
  output logic [C_AVM_DATA_WIDTH/8-1:0] avm_byteenable,
  output logic                          avm_read,
  output logic                          avm_write,
  output logic [C_AVM_DATA_WIDTH-1:0]   avm_writedata,
  input  logic                          avm_waitrequest,
  input  logic [C_AVM_DATA_WIDTH-1:0]   avm_readdata,
  input  logic                          avm_readdatavalid
);

  localparam int BEAT_W = beat_cnt_width(C_MAX_BURST);
  localparam int BYTES  = C_AVM_DATA_WIDTH / 8;

  state_e                      state_q, state_d;
  logic [C_AVM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]            rem_q, rem_d;
  logic [BEAT_W-1:0]           beat_q, beat_d;
  logic [LEN_W-1:0]            ret_q, ret_d;
  logic                        awready_q, awready_d;
  logic                        arready_q, arready_d;
  logic                        error_q, error_d;

  logic [LEN_W-1:0]            sub;
  logic [C_AVM_ADDR_WIDTH-1:0] addr_step;
  logic                        sub_last_beat;
  logic                        final_sub;
  logic                        accept_beat;
  logic                        wlast_err;
  logic                        orphan_beat;
  logic                        rlast_c;
  logic                        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [LEN_W-1:0]            fifo_head;
  logic                        unused_rready;

  // The read return path has no backpressure, so rready carries no information.
  assign unused_rready = rready;

  assign sub           = (rem_q > LEN_W'(C_MAX_BURST)) ? LEN_W'(C_MAX_BURST) : rem_q;
  assign addr_step     = C_AVM_ADDR_WIDTH'(sub) * C_AVM_ADDR_WIDTH'(BYTES);
  assign sub_last_beat = (beat_q == BEAT_W'(sub - 9'd1));
  assign final_sub     = (rem_q == sub);
  assign accept_beat   = (state_q == ST_WRITE) && wvalid && !avm_waitrequest;

  assign awready        = awready_q;
  assign arready        = arready_q;
  assign error          = error_q;
  assign avm_address    = addr_q;
  assign avm_burstcount = (rem_q == '0) ? BCW'(1) : BCW'(sub);
  assign avm_write      = (state_q == ST_WRITE) && wvalid;
  assign avm_read       = (state_q == ST_READ);
  assign wready         = (state_q == ST_WRITE) && !avm_waitrequest;
  assign avm_writedata  = (state_q == ST_WRITE) ? wdata : '0;
  assign avm_byteenable = (state_q == ST_WRITE) ? wstrb :
                          (state_q == ST_READ)  ? '1    : '0;
  assign rvalid         = avm_readdatavalid;
  assign rdata          = avm_readdata;
  assign rlast          = rlast_c;

  avalon_len_fifo #(
    .DEPTH (C_MAX_OUTSTANDING),
    .WIDTH (LEN_W)
  ) u_len_fifo (
    .clk       (ACLK),
    .rst       (ARESET),
    .push      (fifo_push),
    .push_data ({1'b0, arlen} + 9'd1),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Command FSM: accepts user commands and walks address/remaining through sub-bursts.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    beat_d    = beat_q;
    awready_d = 1'b0;
    arready_d = 1'b0;
    fifo_push = 1'b0;
    wlast_err = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (awvalid) begin
          awready_d = 1'b1;
          addr_d    = awaddr + C_AVM_TARGET;
          rem_d     = {1'b0, awlen} + 9'd1;
          beat_d    = '0;
          state_d   = ST_WRITE;
        end else if (arvalid && !fifo_full) begin
          arready_d = 1'b1;
          addr_d    = araddr + C_AVM_TARGET;
          rem_d     = {1'b0, arlen} + 9'd1;
          fifo_push = 1'b1;
          state_d   = ST_READ;
        end
      end
      ST_WRITE: begin
        if (accept_beat) begin
          wlast_err = (wlast != (final_sub && sub_last_beat));
          if (sub_last_beat) begin
            beat_d = '0;
            rem_d  = rem_q - sub;
            addr_d = addr_q + addr_step;
            if (final_sub) state_d = ST_IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      ST_READ: begin
        if (!avm_waitrequest) begin
          rem_d  = rem_q - sub;
          addr_d = addr_q + addr_step;
          if (final_sub) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read return tracking: count beats against the oldest command length and flag orphans.
  always_comb begin
    ret_d       = ret_q;
    fifo_pop    = 1'b0;
    rlast_c     = 1'b0;
    orphan_beat = 1'b0;
    if (avm_readdatavalid) begin
      if (fifo_empty) begin
        orphan_beat = 1'b1;
      end else if (ret_q == fifo_head - 9'd1) begin
        rlast_c  = 1'b1;
        fifo_pop = 1'b1;
        ret_d    = '0;
      end else begin
        ret_d = ret_q + 9'd1;
      end
    end
  end

  // Sticky protocol error: only a reset clears it.
  always_comb begin
    error_d = error_q || wlast_err || orphan_beat;
  end

  // State registers.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      beat_q    <= '0;
      ret_q     <= '0;
      awready_q <= 1'b0;
      arready_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      beat_q    <= beat_d;
      ret_q     <= ret_d;
      awready_q <= awready_d;
      arready_q <= arready_d;
      error_q   <= error_d;
    end
  end

endmodule

// File: tb/tb_avalon_burst_master.sv
// Directed bench for avalon_burst_master with a small Avalon slave and reference burst model.
`timescale 1ns/1ps
module tb_avalon_burst_master;

   localparam int MAXB = 16;
   localparam int MAXO = 4;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic        awvalid, awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast, wvalid, wready;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic        arvalid, arready;
   logic [31:0] rdata;
   logic        rlast, rvalid, rready, error;
   logic [31:0] avm_address;
   logic [4:0]  avm_burstcount;
   logic [3:0]  avm_byteenable;
   logic        avm_read, avm_write;
   logic [31:0] avm_writedata;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;
   logic        avm_readdatavalid;

   typedef struct {
      logic [31:0] addr;
      logic [4:0]  bc;
      logic [31:0] data;
      logic [3:0]  be;
      int          cyc;
   } wBeat_t;
   typedef struct {
      logic [31:0] addr;
      logic [4:0]  bc;
   } rCmd_t;
   typedef struct {
      logic [31:0] data;
      logic        last;
   } rBeat_t;

   wBeat_t wrLog[$];
   rCmd_t  rdCmdLog[$];
   rBeat_t rdBeatLog[$];

   int checks = 0;
   int passes = 0;
   int cycleCount = 0;
   int issuedBeats = 0;
   int returnedBeats = 0;
   int spuriousReq = 0;
   int spuriousDone = 0;
   int expData = 0;
   bit returnEn = 1'b1;
   bit randReturn = 1'b0;
   bit randWait = 1'b0;

   avalon_burst_master #(
      .C_AVM_ADDR_WIDTH  (32),
      .C_AVM_DATA_WIDTH  (32),
      .C_AVM_TARGET      (32'h0),
      .C_MAX_BURST       (MAXB),
      .C_MAX_OUTSTANDING (MAXO)
   ) dut (
      .ACLK              (ACLK),
      .ARESET            (ARESET),
      .awaddr            (awaddr),
      .awlen             (awlen),
      .awvalid           (awvalid),
      .awready           (awready),
      .wdata             (wdata),
      .wstrb             (wstrb),
      .wlast             (wlast),
      .wvalid            (wvalid),
      .wready            (wready),
      .araddr            (araddr),
      .arlen             (arlen),
      .arvalid           (arvalid),
      .arready           (arready),
      .rdata             (rdata),
      .rlast             (rlast),
      .rvalid            (rvalid),
      .rready            (rready),
      .error             (error),
      .avm_address       (avm_address),
      .avm_burstcount    (avm_burstcount),
      .avm_byteenable    (avm_byteenable),
      .avm_read          (avm_read),
      .avm_write         (avm_write),
      .avm_writedata     (avm_writedata),
      .avm_waitrequest   (avm_waitrequest),
      .avm_readdata      (avm_readdata),
      .avm_readdatavalid (avm_readdatavalid)
   );

   // 100 MHz clock and a free-running cycle counter.
   always #5 ACLK = ~ACLK;

   initial forever begin
      @(posedge ACLK);
      cycleCount++;
   end

   // Slave stall generator: roughly 30% of cycles stalled when enabled.
   initial begin
      avm_waitrequest = 1'b0;
      forever begin
         @(posedge ACLK);
         #1;
         avm_waitrequest = randWait && ($urandom_range(0, 99) < 30);
      end
   end

   // Slave read return: emits one beat per owed beat, plus injected orphan beats on request.
   initial begin
      avm_readdatavalid = 1'b0;
      avm_readdata      = 32'h0;
      forever begin
         @(posedge ACLK);
         #1;
         if (spuriousReq != spuriousDone) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = 32'hBAD0_0001;
            spuriousDone++;
         end else if (returnEn && (issuedBeats > returnedBeats) &&
                      (!randReturn || ($urandom_range(0, 9) < 7))) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = 32'hD000_0000 + returnedBeats;
            returnedBeats++;
         end else begin
            avm_readdatavalid = 1'b0;
            avm_readdata      = 32'h0;
         end
      end
   end

   // Bus monitor: records accepted Avalon write beats, read commands and user read beats.
   initial forever begin
      @(negedge ACLK);
      if (!ARESET) begin
         if (avm_write && !avm_waitrequest)
            wrLog.push_back('{avm_address, avm_burstcount, avm_writedata, avm_byteenable, cycleCount});
         if (avm_read && !avm_waitrequest) begin
            rdCmdLog.push_back('{avm_address, avm_burstcount});
            issuedBeats += int'(avm_burstcount);
         end
         if (rvalid)
            rdBeatLog.push_back('{rdata, rlast});
      end
   end

   // Hard stop in case a handshake never completes outside a bounded wait.
   initial begin
      #600000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Waits up to maxCycles for awready/arready; always returns just after a rising edge.
   task automatic waitCmdReady(input bit isWrite, input int maxCycles, output bit seen);
      seen = 1'b0;
      for (int n = 0; n < maxCycles; n++) begin
         @(negedge ACLK);
         seen = isWrite ? awready : arready;
         @(posedge ACLK);
         #1;
         if (seen) break;
      end
   endtask

   // Issues one user command; for writes also streams all beats with no gaps.
   task automatic applyStimulus(input bit isWrite, input logic [31:0] addr, input logic [7:0] len,
                                input logic [31:0] seed, input int badLast, output bit ok);
      bit accepted;
      int n;
      @(posedge ACLK);
      #1;
      if (isWrite) begin
         awaddr = addr; awlen = len; awvalid = 1'b1;
      end else begin
         araddr = addr; arlen = len; arvalid = 1'b1;
      end
      waitCmdReady(isWrite, 50, ok);
      awvalid = 1'b0;
      arvalid = 1'b0;
      checkOutput(isWrite ? "aw_accept" : "ar_accept", {31'b0, ok}, 32'd1);
      if (ok && isWrite) begin
         for (int i = 0; i <= int'(len); i++) begin
            wdata  = seed + i;
            wstrb  = 4'hF ^ 4'(i & 3);
            wlast  = (badLast >= 0) ? (i == badLast) : (i == int'(len));
            wvalid = 1'b1;
            accepted = 1'b0;
            n = 0;
            while (!accepted && n < 100) begin
               @(negedge ACLK);
               accepted = wready;
               n++;
               @(posedge ACLK);
               #1;
            end
            if (!accepted) begin
               checkOutput("w_beat_accept", 32'd0, 32'd1);
               break;
            end
         end
         wvalid = 1'b0;
         wlast  = 1'b0;
      end
   endtask

   // Reference model for a write: sub-bursts of min(rem, MAXB), address stepping by 4 bytes per beat.
   task automatic verifyWrite(input logic [31:0] addr, input int len, input logic [31:0] seed, input string tag);
      logic [31:0] a;
      int rem, sub, idx;
      checkOutput({tag, "_beats"}, wrLog.size(), len + 1);
      a = addr; rem = len + 1; idx = 0;
      while (rem > 0) begin
         sub = (rem > MAXB) ? MAXB : rem;
         for (int k = 0; k < sub; k++) begin
            if (idx < wrLog.size()) begin
               checkOutput($sformatf("%s_addr%0d", tag, idx), wrLog[idx].addr, a);
               checkOutput($sformatf("%s_bc%0d", tag, idx), {27'b0, wrLog[idx].bc}, sub);
               checkOutput($sformatf("%s_data%0d", tag, idx), wrLog[idx].data, seed + idx);
               checkOutput($sformatf("%s_be%0d", tag, idx), {28'b0, wrLog[idx].be}, {28'b0, 4'hF ^ 4'(idx & 3)});
            end
            idx++;
         end
         a = a + sub * 4;
         rem -= sub;
      end
      wrLog.delete();
   endtask

   // Reference model for a read: expected sub-burst commands, returned data order and rlast position.
   task automatic verifyRead(input logic [31:0] addr, input int len, input string tag);
      logic [31:0] a;
      int rem, sub, c, n;
      n = 0;
      while (rdBeatLog.size() < len + 1 && n < 4000) begin
         @(posedge ACLK);
         n++;
      end
      @(negedge ACLK);
      checkOutput({tag, "_rbeats"}, rdBeatLog.size(), len + 1);
      a = addr; rem = len + 1; c = 0;
      while (rem > 0) begin
         sub = (rem > MAXB) ? MAXB : rem;
         if (c < rdCmdLog.size()) begin
            checkOutput($sformatf("%s_raddr%0d", tag, c), rdCmdLog[c].addr, a);
            checkOutput($sformatf("%s_rbc%0d", tag, c), {27'b0, rdCmdLog[c].bc}, sub);
         end
         c++;
         a = a + sub * 4;
         rem -= sub;
      end
      checkOutput({tag, "_rcmds"}, rdCmdLog.size(), c);
      for (int i = 0; i < rdBeatLog.size() && i <= len; i++) begin
         checkOutput($sformatf("%s_rdata%0d", tag, i), rdBeatLog[i].data, 32'hD000_0000 + expData + i);
         checkOutput($sformatf("%s_rlast%0d", tag, i), {31'b0, rdBeatLog[i].last}, {31'b0, i == len});
      end
      expData += len + 1;
      rdBeatLog.delete();
      rdCmdLog.delete();
   endtask

   initial begin
      bit ok, seen;
      int pulses, n;

      ARESET  = 1'b1;
      awaddr  = '0; awlen = '0; awvalid = 1'b0;
      wdata   = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
      araddr  = '0; arlen = '0; arvalid = 1'b0;
      rready  = 1'b1;
      repeat (2) @(posedge ACLK);
      @(negedge ACLK);
      checkOutput("rst_awready", {31'b0, awready}, 32'd0);
      checkOutput("rst_arready", {31'b0, arready}, 32'd0);
      checkOutput("rst_wready", {31'b0, wready}, 32'd0);
      checkOutput("rst_rvalid", {31'b0, rvalid}, 32'd0);
      checkOutput("rst_rlast", {31'b0, rlast}, 32'd0);
      checkOutput("rst_error", {31'b0, error}, 32'd0);
      checkOutput("rst_avm_read", {31'b0, avm_read}, 32'd0);
      checkOutput("rst_avm_write", {31'b0, avm_write}, 32'd0);
      checkOutput("rst_burstcount", {27'b0, avm_burstcount}, 32'd1);
      checkOutput("rst_address", avm_address, 32'd0);
      checkOutput("rst_byteenable", {28'b0, avm_byteenable}, 32'd0);
      checkOutput("rst_writedata", avm_writedata, 32'd0);
      @(posedge ACLK);
      #1;
      ARESET = 1'b0;

      $display("[TB] short write burst");
      applyStimulus(1'b1, 32'h100, 8'd3, 32'h1000_0000, -1, ok);
      verifyWrite(32'h100, 3, 32'h1000_0000, "t1");
      @(negedge ACLK);
      checkOutput("t1_idle_wready", {31'b0, wready}, 32'd0);
      checkOutput("t1_error", {31'b0, error}, 32'd0);

      $display("[TB] 40-beat write split 16/16/8");
      applyStimulus(1'b1, 32'h0, 8'd39, 32'h1100_0000, -1, ok);
      if (wrLog.size() == 40)
         checkOutput("t2_no_gap", wrLog[39].cyc - wrLog[0].cyc, 32'd39);
      verifyWrite(32'h0, 39, 32'h1100_0000, "t2");
      checkOutput("t2_error", {31'b0, error}, 32'd0);

      $display("[TB] 20-beat read split 16/4");
      applyStimulus(1'b0, 32'h200, 8'd19, 32'h0, -1, ok);
      verifyRead(32'h200, 19, "t3");

      $display("[TB] outstanding read limit");
      returnEn = 1'b0;
      pulses = 0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 32'h300 + 32'(i * 16), 8'd0, 32'h0, -1, ok);
         pulses += int'(ok);
      end
      checkOutput("t4_pulses", pulses, 32'd4);
      araddr = 32'h340; arlen = 8'd0; arvalid = 1'b1;
      waitCmdReady(1'b0, 20, seen);
      checkOutput("t4_fifth_stalls", {31'b0, seen}, 32'd0);
      returnEn = 1'b1;
      waitCmdReady(1'b0, 40, seen);
      arvalid = 1'b0;
      checkOutput("t4_fifth_accepted", {31'b0, seen}, 32'd1);
      checkOutput("t4_accept_after_return", {31'b0, returnedBeats > expData}, 32'd1);
      n = 0;
      while (rdBeatLog.size() < 5 && n < 200) begin
         @(posedge ACLK);
         n++;
      end
      @(negedge ACLK);
      checkOutput("t4_rbeats", rdBeatLog.size(), 32'd5);
      checkOutput("t4_rcmds", rdCmdLog.size(), 32'd5);
      for (int i = 0; i < rdCmdLog.size() && i < 5; i++)
         checkOutput($sformatf("t4_raddr%0d", i), rdCmdLog[i].addr, 32'h300 + 32'(i * 16));
      for (int i = 0; i < rdBeatLog.size() && i < 5; i++) begin
         checkOutput($sformatf("t4_rdata%0d", i), rdBeatLog[i].data, 32'hD000_0000 + expData + i);
         checkOutput($sformatf("t4_rlast%0d", i), {31'b0, rdBeatLog[i].last}, 32'd1);
      end
      expData += 5;
      rdBeatLog.delete();
      rdCmdLog.delete();

      $display("[TB] mixed traffic with random stalls");
      randWait   = 1'b1;
      randReturn = 1'b1;
      applyStimulus(1'b1, 32'h1000, 8'd20, 32'h2000_0000, -1, ok);
      verifyWrite(32'h1000, 20, 32'h2000_0000, "t6a");
      applyStimulus(1'b0, 32'h2000, 8'd33, 32'h0, -1, ok);
      verifyRead(32'h2000, 33, "t6b");
      applyStimulus(1'b1, 32'hFFFF_FFC0, 8'd16, 32'h3000_0000, -1, ok);
      verifyWrite(32'hFFFF_FFC0, 16, 32'h3000_0000, "t6c");
      applyStimulus(1'b0, 32'hFFFF_FFE0, 8'd17, 32'h0, -1, ok);
      verifyRead(32'hFFFF_FFE0, 17, "t6d");
      applyStimulus(1'b1, 32'h3000, 8'd0, 32'h4000_0000, -1, ok);
      verifyWrite(32'h3000, 0, 32'h4000_0000, "t6e");
      applyStimulus(1'b0, 32'h4000, 8'd255, 32'h0, -1, ok);
      verifyRead(32'h4000, 255, "t6f");
      checkOutput("t6_error", {31'b0, error}, 32'd0);
      randWait   = 1'b0;
      randReturn = 1'b0;

      $display("[TB] protocol errors");
      applyStimulus(1'b1, 32'h500, 8'd3, 32'h5000_0000, 1, ok);
      wrLog.delete();
      @(negedge ACLK);
      checkOutput("t5_wlast_error", {31'b0, error}, 32'd1);
      applyStimulus(1'b1, 32'h600, 8'd1, 32'h6000_0000, -1, ok);
      wrLog.delete();
      repeat (3) @(negedge ACLK);
      checkOutput("t5_error_sticky", {31'b0, error}, 32'd1);
      @(posedge ACLK);
      #1;
      ARESET = 1'b1;
      @(negedge ACLK);
      checkOutput("t5_error_cleared", {31'b0, error}, 32'd0);
      @(posedge ACLK);
      #1;
      ARESET = 1'b0;
      @(negedge ACLK);
      spuriousReq++;
      @(negedge ACLK);
      checkOutput("t5_orphan_rvalid", {31'b0, rvalid}, 32'd1);
      checkOutput("t5_orphan_rdata", rdata, 32'hBAD0_0001);
      checkOutput("t5_orphan_rlast", {31'b0, rlast}, 32'd0);
      @(negedge ACLK);
      checkOutput("t5_orphan_error", {31'b0, error}, 32'd1);
      rdBeatLog.delete();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
